mem_resp_queue: RTL and testbench

Parametrised in-order memory-response queue for the memory stage. It accepts load and store requests at issue time and keeps up to DEPTH of them outstanding. It captures each cache `data_data_ok`/`data_rdata` response into the oldest waiting entry, aligns and sign- or zero-extends load data for DATA_W of 32 or 64, and hands finished entries to writeback over a valid/allowin handshake. A flush discards all entries but silently absorbs responses still owed by the cache, so the pipeline can restart without waiting for the bus to drain.

---
 rtl/mem_resp_queue.sv | 158 +++++++++++++++
 tb/tb_mem_resp_queue.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_resp_queue.sv
// rtl/mem_resp_queue.sv - in-order memory response queue with load alignment and flush drop tracking
module mem_resp_queue #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    localparam int IDX_W = $clog2(DEPTH),
    localparam int OFF_W = $clog2(DATA_W / 8)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_load,
    input  logic [1:0]        req_size,
    input  logic              req_sign,
    input  logic [OFF_W-1:0]  req_offset,
    input  logic [4:0]        req_dest,
    input  logic [31:0]       req_pc,
    input  logic              data_data_ok,
    input  logic [DATA_W-1:0] data_rdata,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_allowin,
    output logic              out_load,
    output logic [4:0]        out_dest,
    output logic [31:0]       out_pc,
    output logic [DATA_W-1:0] out_result,
    output logic [IDX_W:0]    pending_cnt,
    output logic [IDX_W:0]    drop_cnt,
    output logic              resp_err
);

    logic [IDX_W-1:0]  wr_ptr, rsp_ptr, rd_ptr;
    logic [IDX_W:0]    cnt, drop_q, drop_flush;
    logic              err_q;
    logic [DEPTH-1:0]  e_valid, e_done;
    logic              e_load   [DEPTH];
    logic [1:0]        e_size   [DEPTH];
    logic              e_sign   [DEPTH];
    logic [OFF_W-1:0]  e_off    [DEPTH];
    logic [4:0]        e_dest   [DEPTH];
    logic [31:0]       e_pc     [DEPTH];
    logic [DATA_W-1:0] e_result [DEPTH];

    logic enq, deq, rsp_owner, rsp_drop, rsp_hit, rsp_orphan;
    logic [IDX_W+1:0] owed, total, after_ok;

    assign req_ready   = (cnt != (IDX_W+1)'(DEPTH));
    assign out_valid   = e_valid[rd_ptr] & e_done[rd_ptr];
    assign out_load    = e_load[rd_ptr];
    assign out_dest    = e_dest[rd_ptr];
    assign out_pc      = e_pc[rd_ptr];
    assign out_result  = e_result[rd_ptr];
    assign pending_cnt = cnt;
    assign drop_cnt    = drop_q;
    assign resp_err    = err_q;

    assign enq        = req_valid & req_ready & ~flush;
    assign deq        = out_valid & out_allowin & ~flush;
    assign rsp_owner  = e_valid[rsp_ptr] & ~e_done[rsp_ptr];
    assign rsp_drop   = data_data_ok & (drop_q != '0);
    assign rsp_hit    = data_data_ok & (drop_q == '0) & rsp_owner;
    assign rsp_orphan = data_data_ok & (drop_q == '0) & ~rsp_owner;

    // Responses still owed after a flush: outstanding entries plus earlier drops, less one arriving now.
    always_comb begin
        owed = '0;
        for (int i = 0; i < DEPTH; i++)
            owed = owed + (IDX_W+2)'(e_valid[i] & ~e_done[i]);
        total    = owed + {1'b0, drop_q};
        after_ok = (data_data_ok && total != '0) ? total - 1'b1 : total;
        drop_flush = (after_ok > (IDX_W+2)'(DEPTH)) ? (IDX_W+1)'(DEPTH) : after_ok[IDX_W:0];
    end

    logic [1:0]        a_size;
    logic              a_sign, a_load;
    logic [OFF_W-1:0]  a_off, a_aoff;
    logic [DATA_W-1:0] a_sh, a_res;

    always_comb begin
        a_size = e_size[rsp_ptr];
        a_sign = e_sign[rsp_ptr];
        a_load = e_load[rsp_ptr];
        a_off  = e_off[rsp_ptr];
        case (a_size)
            2'b00:   a_aoff = a_off;
            2'b01:   a_aoff = a_off & ~OFF_W'(1);
            default: a_aoff = a_off & ~OFF_W'(3);
        endcase
        a_sh = data_rdata >> {a_aoff, 3'b000};
        case (a_size)
            2'b00:   a_res = a_sign ? DATA_W'($signed(a_sh[7:0]))  : DATA_W'(a_sh[7:0]);
            2'b01:   a_res = a_sign ? DATA_W'($signed(a_sh[15:0])) : DATA_W'(a_sh[15:0]);
            default: a_res = a_sign ? DATA_W'($signed(a_sh[31:0])) : DATA_W'(a_sh[31:0]);
        endcase
        if (DATA_W == 64 && a_size == 2'b11)
            a_res = data_rdata;
        if (!a_load)
            a_res = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rsp_ptr <= '0;
            rd_ptr  <= '0;
            cnt     <= '0;
            drop_q  <= '0;
            err_q   <= 1'b0;
            e_valid <= '0;
            e_done  <= '0;
        end else begin
            if (rsp_orphan)
                err_q <= 1'b1;
            if (flush) begin
                wr_ptr  <= '0;
                rsp_ptr <= '0;
                rd_ptr  <= '0;
                cnt     <= '0;
                drop_q  <= drop_flush;
                e_valid <= '0;
                e_done  <= '0;
            end else begin
                if (enq) begin
                    e_valid[wr_ptr] <= 1'b1;
                    e_done[wr_ptr]  <= 1'b0;
                    wr_ptr          <= wr_ptr + 1'b1;
                end
                if (rsp_hit) begin
                    e_done[rsp_ptr] <= 1'b1;
                    rsp_ptr         <= rsp_ptr + 1'b1;
                end
                if (rsp_drop)
                    drop_q <= drop_q - 1'b1;
                if (deq) begin
                    e_valid[rd_ptr] <= 1'b0;
                    e_done[rd_ptr]  <= 1'b0;
                    rd_ptr          <= rd_ptr + 1'b1;
                end
                cnt <= cnt + (IDX_W+1)'(enq) - (IDX_W+1)'(deq);
            end
        end
    end

    // Payload storage needs no reset: done/valid bits gate every use of it.
    always_ff @(posedge clk) begin
        if (enq) begin
            e_load[wr_ptr] <= req_load;
            e_size[wr_ptr] <= req_size;
            e_sign[wr_ptr] <= req_sign;
            e_off[wr_ptr]  <= req_offset;
            e_dest[wr_ptr] <= req_dest;
            e_pc[wr_ptr]   <= req_pc;
        end
        if (rsp_hit && !flush)
            e_result[rsp_ptr] <= a_res;
    end

endmodule

// File: tb/tb_mem_resp_queue.sv
// tb/tb_mem_resp_queue.sv - scoreboard bench for mem_resp_queue at DATA_W 32 and 64
module tb_mem_resp_queue;

    typedef struct packed {
        logic        load;
        logic [4:0]  dest;
        logic [31:0] pc;
        logic [31:0] result;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic        req_valid = 0, req_load = 0, req_sign = 0, data_ok = 0, flush = 0, out_allowin = 1;
    logic [1:0]  req_size = 0, req_offset = 0;
    logic [4:0]  req_dest = 0;
    logic [31:0] req_pc = 0, rdata = 0;
    logic        req_ready, out_valid, out_load, resp_err;
    logic [4:0]  out_dest;
    logic [31:0] out_pc, out_result;
    logic [2:0]  pending_cnt, drop_cnt;

    logic        v64_req_valid = 0, v64_sign = 0, v64_ok = 0;
    logic [1:0]  v64_size = 0;
    logic [2:0]  v64_off = 0;
    logic [63:0] v64_rdata = 0;
    logic        v64_ready, v64_out_valid, v64_out_load, v64_err;
    logic [4:0]  v64_out_dest;
    logic [31:0] v64_out_pc;
    logic [63:0] v64_out_result;
    logic [2:0]  v64_pending, v64_drop;

    exp_t        sb[$];
    logic [63:0] sb64[$];

    mem_resp_queue #(.DATA_W(32), .DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_load(req_load), .req_size(req_size),
        .req_sign(req_sign), .req_offset(req_offset), .req_dest(req_dest), .req_pc(req_pc),
        .data_data_ok(data_ok), .data_rdata(rdata), .flush(flush),
        .out_valid(out_valid), .out_allowin(out_allowin), .out_load(out_load), .out_dest(out_dest),
        .out_pc(out_pc), .out_result(out_result), .pending_cnt(pending_cnt), .drop_cnt(drop_cnt),
        .resp_err(resp_err)
    );

    mem_resp_queue #(.DATA_W(64), .DEPTH(4)) dut64 (
        .clk(clk), .reset(reset),
        .req_valid(v64_req_valid), .req_ready(v64_ready), .req_load(1'b1), .req_size(v64_size),
        .req_sign(v64_sign), .req_offset(v64_off), .req_dest(5'd7), .req_pc(32'h0),
        .data_data_ok(v64_ok), .data_rdata(v64_rdata), .flush(1'b0),
        .out_valid(v64_out_valid), .out_allowin(1'b1), .out_load(v64_out_load), .out_dest(v64_out_dest),
        .out_pc(v64_out_pc), .out_result(v64_out_result), .pending_cnt(v64_pending), .drop_cnt(v64_drop),
        .resp_err(v64_err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic ld, input logic [1:0] sz, input logic sg, input logic [1:0] off,
                         input logic [4:0] dst, input logic [31:0] pc, input logic push, input logic [31:0] res);
        exp_t e;
        req_valid = 1; req_load = ld; req_size = sz; req_sign = sg; req_offset = off;
        req_dest = dst; req_pc = pc;
        e.load = ld; e.dest = dst; e.pc = pc; e.result = res;
        if (push) sb.push_back(e);
        tick();
        req_valid = 0;
    endtask

    task automatic respond(input logic [31:0] d);
        data_ok = 1; rdata = d;
        tick();
        data_ok = 0;
    endtask

    task automatic run64(input logic [1:0] sz, input logic sg, input logic [2:0] off,
                         input logic [63:0] d, input logic [63:0] res);
        v64_req_valid = 1; v64_size = sz; v64_sign = sg; v64_off = off;
        sb64.push_back(res);
        tick();
        v64_req_valid = 0;
        v64_ok = 1; v64_rdata = d;
        tick();
        v64_ok = 0;
        chk("latency64", v64_out_valid, 1);
        tick();
    endtask

    always @(negedge clk) begin
        if (!reset && out_valid && out_allowin && !flush) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL out_unexpected: got dest %0d result %0h, expected none", out_dest, out_result);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if ({out_load, out_dest, out_pc, out_result} !== e) begin
                    n_fail++;
                    $display("FAIL out_entry: got %0h/%0d/%0h/%0h, expected %0h/%0d/%0h/%0h",
                             out_load, out_dest, out_pc, out_result, e.load, e.dest, e.pc, e.result);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && v64_out_valid) begin
            n_tests++;
            if (sb64.size() == 0) begin
                n_fail++;
                $display("FAIL out64_unexpected: got %0h, expected none", v64_out_result);
            end else begin
                logic [63:0] r;
                r = sb64.pop_front();
                if (v64_out_result !== r) begin
                    n_fail++;
                    $display("FAIL out64_result: got %0h, expected %0h", v64_out_result, r);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(); tick();
        reset = 0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_pending", pending_cnt, 0);
        chk("rst_drop", drop_cnt, 0);
        chk("rst_err", resp_err, 0);

        // sign/zero extension, half, store
        issue(1, 2'b00, 1, 2'd3, 5'd5, 32'h100, 1, 32'hFFFF_FF80);
        respond(32'h80FF_1234);
        chk("latency_byte", out_valid, 1);
        issue(1, 2'b00, 0, 2'd3, 5'd6, 32'h104, 1, 32'h0000_0080);
        respond(32'h80FF_1234);
        issue(1, 2'b01, 1, 2'd3, 5'd8, 32'h108, 1, 32'hFFFF_8001);
        respond(32'h8001_1234);
        issue(0, 2'b10, 0, 2'd0, 5'd0, 32'h10C, 1, 32'h0);
        respond(32'hFFFF_FFFF);
        tick();

        // fill to DEPTH with writeback stalled
        out_allowin = 0;
        for (int i = 0; i < 4; i++)
            issue(1, 2'b10, 0, 2'd0, 5'(i + 1), 32'h200 + 32'(4 * i), 1, 32'hA000_0000 + 32'(i));
        chk("full_ready", req_ready, 0);
        chk("full_pending", pending_cnt, 4);
        for (int i = 0; i < 4; i++)
            respond(32'hA000_0000 + 32'(i));
        chk("stall_hold", out_result, 32'hA000_0000);
        out_allowin = 1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_valid", out_valid, 1);
            tick();
        end
        chk("drain_pending", pending_cnt, 0);

        // flush with two responses owed
        out_allowin = 0;
        for (int i = 0; i < 3; i++)
            issue(1, 2'b10, 0, 2'd0, 5'd9, 32'h300, 0, 32'h0);
        respond(32'h1111_1111);
        flush = 1; tick(); flush = 0;
        chk("flush_drop", drop_cnt, 2);
        chk("flush_pending", pending_cnt, 0);
        out_allowin = 1;
        issue(1, 2'b00, 0, 2'd1, 5'd10, 32'h400, 1, 32'h0000_00AB);
        respond(32'hDEAD_BEEF);
        respond(32'hDEAD_BEEF);
        chk("drop_after2", drop_cnt, 0);
        respond(32'h0000_AB00);
        chk("flush_new_valid", out_valid, 1);
        chk("flush_err", resp_err, 0);
        tick();

        // flush coinciding with a response
        issue(1, 2'b10, 0, 2'd0, 5'd11, 32'h500, 0, 32'h0);
        issue(1, 2'b10, 0, 2'd0, 5'd11, 32'h504, 0, 32'h0);
        flush = 1; data_ok = 1; rdata = 32'h5555_5555;
        tick();
        flush = 0; data_ok = 0;
        chk("flush_ok_drop", drop_cnt, 1);
        respond(32'h6666_6666);
        chk("flush_ok_drained", drop_cnt, 0);

        // drop_cnt saturation
        for (int i = 0; i < 4; i++)
            issue(1, 2'b10, 0, 2'd0, 5'd12, 32'h600, 0, 32'h0);
        flush = 1; tick(); flush = 0;
        chk("sat_drop4", drop_cnt, 4);
        for (int i = 0; i < 4; i++)
            issue(1, 2'b10, 0, 2'd0, 5'd12, 32'h600, 0, 32'h0);
        flush = 1; tick(); flush = 0;
        chk("sat_drop_cap", drop_cnt, 4);
        for (int i = 0; i < 4; i++)
            respond(32'h7777_7777);
        chk("sat_drained", drop_cnt, 0);
        chk("sat_err", resp_err, 0);

        // orphan response
        respond(32'h8888_8888);
        chk("orphan_err", resp_err, 1);
        tick(); tick();
        chk("orphan_sticky", resp_err, 1);

        // asynchronous reset mid-fill
        out_allowin = 0;
        for (int i = 0; i < 4; i++)
            issue(1, 2'b10, 0, 2'd0, 5'd13, 32'h700, 0, 32'h0);
        respond(32'h9999_9999);
        chk("pre_rst_valid", out_valid, 1);
        chk("pre_rst_ready", req_ready, 0);
        #2 reset = 1;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_req_ready", req_ready, 1);
        chk("arst_pending", pending_cnt, 0);
        chk("arst_drop", drop_cnt, 0);
        chk("arst_err", resp_err, 0);
        tick();
        reset = 0;
        out_allowin = 1;
        tick();

        // 64-bit datapath alignment
        run64(2'b01, 1, 3'd6, 64'h8001_0000_0000_0000, 64'hFFFF_FFFF_FFFF_8001);
        run64(2'b11, 0, 3'd0, 64'h8123_4567_89AB_CDEF, 64'h8123_4567_89AB_CDEF);
        run64(2'b10, 0, 3'd5, 64'hCAFE_F00D_1234_5678, 64'h0000_0000_CAFE_F00D);
        run64(2'b00, 1, 3'd7, 64'hF0FF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF0);
        tick();

        chk("sb_empty", 64'(sb.size()), 0);
        chk("sb64_empty", 64'(sb64.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
